subtractor32_serial: RTL and testbench
======================================

# subtractor32_serial

Digit-serial 32-bit subtractor computing `a - b - borrow` over several clock cycles, one 4-bit digit per cycle, LSB digit first. It is the inverse-direction companion to the ripple-carry 32-bit adder. It serves area-constrained datapaths that can tolerate multi-cycle latency. Operands enter and results leave through valid/ready handshakes.

## Interface
- `WIDTH`, 32: operand width; must be a multiple of `DIGIT_W`.
- `DIGIT_W`, 4: bits processed per cycle.
- `clk_i` input 1: clock; all state changes on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `valid_i` input 1: operands valid.
- `ready_o` output 1: block can accept operands (registered).
- `a_i` input WIDTH: minuend.
- `b_i` input WIDTH: subtrahend.
- `borrow_i` input 1: incoming borrow.
- `valid_o` output 1: result valid.
- `ready_i` input 1: consumer accepts result.
- `diff_o` output WIDTH: `a - b - borrow` mod 2^WIDTH.
- `borrow_o` output 1: final borrow out.
- `zero_o` output 1: `diff_o == 0`.
- `overflow_o` output 1: signed overflow; present only with the macro described under Configuration.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - `ready_o` is 1.
  - On `valid_i && ready_o`, capture `a_i`, `b_i` and `borrow_i` into shift/borrow registers and clear the digit counter. Go to BUSY.
- BUSY:
  - Each cycle, subtract the low digit of a and b with the registered borrow.
  - Shift the digit result into `diff` from the MSB side and shift the operands right by `DIGIT_W`.
  - Register the digit borrow and increment the counter.
  - After `WIDTH/DIGIT_W` digits (8 by default), go to DONE.
- DONE:
  - `valid_o` is 1.
  - `diff_o`, `borrow_o`, `zero_o` and `overflow_o` hold stable until `valid_o && ready_i`, then go to IDLE.
- Arithmetic:
  - `borrow_o` is 1 iff unsigned `a < b + borrow_i`.
  - `overflow_o` = `(a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, using the captured operands.
- `valid_i` outside IDLE is ignored. Operands are not sampled and no queueing occurs.
- `ready_i` outside DONE has no effect.

## Timing
- Reset values:
  - `ready_o` = 0 while `rst_i` is high; 1 from the first edge after release.
  - `valid_o`, `diff_o`, `borrow_o`, `zero_o` and `overflow_o` = 0.
- Latency: operands accepted at edge k give `valid_o` = 1 after edge k+8, where 8 = `WIDTH/DIGIT_W`.
- `ready_o` falls after acceptance edge k. It rises after the edge at which the output handshake occurs. There is no same-cycle turnaround.
- Minimum occupancy is 10 cycles per operation.
- Output outputs stay registered and stable during back-pressure. They change only on a handshake or reset.
- Reset asserted mid-operation (BUSY or DONE): the operation is aborted immediately and no result is presented.
- `borrow_i` = 1 with `a == b` gives all-ones and `borrow_o` = 1.

## Configuration
- `SUB32_SERIAL_OVERFLOW_EN`:
  - Defined: the `overflow_o` port and its sign-tracking register exist.
  - Undefined: the port and its logic are absent, and all other behaviour is identical.

## Structure
- Shared package `subtractor_pkg` holds:
  - the FSM state enum type `sub_state_t` (IDLE/BUSY/DONE);
  - default `WIDTH` and `DIGIT_W` localparams.
- Sub-module `subtractor4`: combinational `DIGIT_W`-bit subtract with `borrow_i`/`borrow_o`. It is instantiated once and reused every cycle.

## Test plan
- Basic subtract: 0x00000005 − 0x00000003, borrow 0 → `diff_o` = 0x00000002, `borrow_o` = 0, `zero_o` = 0. `valid_o` rises exactly 8 cycles after the accept edge.
- Underflow: 0x00000000 − 0x00000001 → `diff_o` = 0xFFFFFFFF, `borrow_o` = 1. Then 0x1234 − 0x1234 with borrow_i = 1 → 0xFFFFFFFF, `borrow_o` = 1.
- Signed overflow (macro on): 0x80000000 − 0x00000001 → `diff_o` = 0x7FFFFFFF, `overflow_o` = 1, `borrow_o` = 0.
- Zero flag: 0xDEADBEEF − 0xDEADBEEF, borrow 0 → `diff_o` = 0, `zero_o` = 1.
- Back-pressure: hold `ready_i` = 0 for 5 cycles in DONE → outputs unchanged.
  - `valid_i` = 1 with new operands during BUSY/DONE is ignored.
  - The next op starts only after the handshake and the IDLE cycle.
- Reset mid-op: assert `rst_i` at the 4th BUSY cycle → `valid_o` = 0 and `ready_o` = 0 during reset; `ready_o` = 1 one edge after release. A following 10 − 7 gives 3.

Source files
------------

// File: rtl/subtractor_pkg.sv
// Shared types and default sizing for the digit-serial subtractor.
// Optional signed-overflow output is enabled by defining SUB32_SERIAL_OVERFLOW_EN.
package subtractor_pkg;
   localparam int SUB_WIDTH   = 32;
   localparam int SUB_DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } sub_state_t;
endpackage

// File: rtl/subtractor4.sv
// Combinational single-digit subtractor: {borrow_o, diff_o} = a_i - b_i - borrow_i.
module subtractor4 #(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         borrow_i,
   output logic [W-1:0] diff_o,
   output logic         borrow_o
);
   logic [W:0] w_full;

   // The extra top bit goes negative exactly when a borrow is needed.
   assign w_full   = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, borrow_i};
   assign diff_o   = w_full[W-1:0];
   assign borrow_o = w_full[W];
endmodule

// File: rtl/subtractor32_serial.sv
// Digit-serial a - b - borrow, one DIGIT_W slice per cycle LSB first, valid/ready on both sides.
// Define SUB32_SERIAL_OVERFLOW_EN to add the overflow_o port and its sign-tracking registers.
module subtractor32_serial
   import subtractor_pkg::*;
#(
   parameter int WIDTH   = SUB_WIDTH,
   parameter int DIGIT_W = SUB_DIGIT_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             borrow_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_o,
   output logic             zero_o
`ifdef SUB32_SERIAL_OVERFLOW_EN
  ,output logic             overflow_o
`endif
);
   localparam int NDIG  = WIDTH / DIGIT_W;
   localparam int CNT_W = $clog2(NDIG + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

   sub_state_t r_state, w_state_next;
   logic                     r_ready;
   logic [WIDTH-1:0]         r_a, r_b;
   logic [WIDTH-DIGIT_W-1:0] r_diff;
   logic                     r_borrow;
   logic [CNT_W-1:0]         r_cnt;
   logic [WIDTH-1:0]         r_diff_out;
   logic                     r_borrow_out, r_zero_out;
   logic [DIGIT_W-1:0]       w_digit_diff;
   logic                     w_digit_borrow;
   logic [WIDTH-1:0]         w_diff_full;
   logic                     w_accept, w_last, w_handshake;

   subtractor4 #(.W(DIGIT_W)) u_digit (
      .a_i      (r_a[DIGIT_W-1:0]),
      .b_i      (r_b[DIGIT_W-1:0]),
      .borrow_i (r_borrow),
      .diff_o   (w_digit_diff),
      .borrow_o (w_digit_borrow)
   );

   // Current digit enters from the top; after the last digit this is the whole difference.
   assign w_diff_full = {w_digit_diff, r_diff};

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      w_handshake  = 1'b0;
      case (r_state)
         IDLE: if (valid_i && r_ready) begin
            w_accept     = 1'b1;
            w_state_next = BUSY;
         end
         BUSY: if (r_cnt == LAST_CNT) begin
            w_last       = 1'b1;
            w_state_next = DONE;
         end
         DONE: if (ready_i) begin
            w_handshake  = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_ready <= (w_state_next == IDLE);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_a      <= '0;
         r_b      <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
      end else if (w_accept) begin
         r_a      <= a_i;
         r_b      <= b_i;
         r_borrow <= borrow_i;
         r_cnt    <= '0;
      end else if (r_state == BUSY) begin
         r_a      <= r_a >> DIGIT_W;
         r_b      <= r_b >> DIGIT_W;
         r_diff   <= w_diff_full[WIDTH-1:DIGIT_W];
         r_borrow <= w_digit_borrow;
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end

   // Result registers load once at completion so they stay put under back-pressure.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_diff_out   <= '0;
         r_borrow_out <= 1'b0;
         r_zero_out   <= 1'b0;
      end else if (w_last) begin
         r_diff_out   <= w_diff_full;
         r_borrow_out <= w_digit_borrow;
         r_zero_out   <= (w_diff_full == '0);
      end
   end

`ifdef SUB32_SERIAL_OVERFLOW_EN
   logic r_a_msb, r_b_msb, r_ovf_out;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_a_msb   <= 1'b0;
         r_b_msb   <= 1'b0;
         r_ovf_out <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a_msb <= a_i[WIDTH-1];
            r_b_msb <= b_i[WIDTH-1];
         end
         if (w_last)
            r_ovf_out <= (r_a_msb != r_b_msb) && (w_diff_full[WIDTH-1] != r_a_msb);
      end
   end

   assign overflow_o = r_ovf_out;
`endif

   assign ready_o  = r_ready;
   assign valid_o  = (r_state == DONE);
   assign diff_o   = r_diff_out;
   assign borrow_o = r_borrow_out;
   assign zero_o   = r_zero_out;

   logic w_unused;
   assign w_unused = w_handshake;
endmodule

// File: tb/tb_subtractor32_serial.sv
// Directed bench for subtractor32_serial with a scoreboard of expected results.
module tb_subtractor32_serial;
   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] a_i, b_i;
   logic        borrow_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] diff_o;
   logic        borrow_o;
   logic        zero_o;
`ifdef SUB32_SERIAL_OVERFLOW_EN
   logic        overflow_o;
`endif

   typedef struct {
      logic [31:0] diff;
      logic        borrow;
      logic        zero;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   subtractor32_serial dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .a_i        (a_i),
      .b_i        (b_i),
      .borrow_i   (borrow_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .diff_o     (diff_o),
      .borrow_o   (borrow_o),
      .zero_o     (zero_o)
`ifdef SUB32_SERIAL_OVERFLOW_EN
     ,.overflow_o (overflow_o)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
      exp_t e;
      e.diff   = a - b - {31'd0, bin};
      e.borrow = ({1'b0, a} < ({1'b0, b} + {32'd0, bin}));
      e.zero   = (e.diff == 32'd0);
      e.ovf    = (a[31] != b[31]) && (e.diff[31] != a[31]);
      return e;
   endfunction

   task automatic chk_outputs(input string tag, input exp_t e);
      chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
      chk({tag, "_diff"}, diff_o, e.diff);
      chk({tag, "_borrow"}, {31'd0, borrow_o}, {31'd0, e.borrow});
      chk({tag, "_zero"}, {31'd0, zero_o}, {31'd0, e.zero});
`ifdef SUB32_SERIAL_OVERFLOW_EN
      chk({tag, "_ovf"}, {31'd0, overflow_o}, {31'd0, e.ovf});
`endif
   endtask

   // One operation: accept, measure latency, optionally back-pressure, then handshake.
   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input int hold, input bit noise);
      exp_t e;
      int   lat;
      for (int i = 0; i < 40 && !ready_o; i++) tick();
      chk({tag, "_ready_before"}, {31'd0, ready_o}, 32'd1);
      a_i = a; b_i = b; borrow_i = bin; valid_i = 1'b1;
      tick();
      sb.push_back(model(a, b, bin));
      if (noise) begin
         a_i = $urandom; b_i = $urandom; borrow_i = 1'b1;
      end else begin
         valid_i = 1'b0;
      end
      chk({tag, "_ready_after_accept"}, {31'd0, ready_o}, 32'd0);
      lat = 0;
      while (!valid_o && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd8);
      if (sb.size() == 0) begin
         chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         for (int h = 0; h <= hold; h++) begin
            if (h > 0) tick();
            chk_outputs(tag, e);
            chk({tag, "_ready_in_done"}, {31'd0, ready_o}, 32'd0);
         end
      end
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      valid_i = 1'b0;
      chk({tag, "_valid_after_hs"}, {31'd0, valid_o}, 32'd0);
      chk({tag, "_ready_after_hs"}, {31'd0, ready_o}, 32'd1);
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
      $display("op %s: a=%h b=%h bin=%0d diff=%h borrow=%0d zero=%0d lat=%0d",
               tag, a, b, bin, diff_o, borrow_o, zero_o, lat);
   endtask

   initial begin
      rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
      a_i = '0; b_i = '0; borrow_i = 1'b0;
      tick();
      tick();
      chk("rst_ready", {31'd0, ready_o}, 32'd0);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_diff", diff_o, 32'd0);
      chk("rst_borrow", {31'd0, borrow_o}, 32'd0);
      chk("rst_zero", {31'd0, zero_o}, 32'd0);
`ifdef SUB32_SERIAL_OVERFLOW_EN
      chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
`endif
      rst = 1'b0;
      #1;
      chk("release_ready_pre_edge", {31'd0, ready_o}, 32'd0);
      tick();
      chk("release_ready", {31'd0, ready_o}, 32'd1);

      do_op("basic",     32'h0000_0005, 32'h0000_0003, 1'b0, 0, 1'b0);
      do_op("underflow", 32'h0000_0000, 32'h0000_0001, 1'b0, 0, 1'b0);
      do_op("eq_borrow", 32'h0000_1234, 32'h0000_1234, 1'b1, 0, 1'b0);
      do_op("signed_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 0, 1'b0);
      do_op("zero",      32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
      do_op("backpress", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 5, 1'b1);
      do_op("after_bp",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
      for (int i = 0; i < 4; i++)
         do_op("random", $urandom, $urandom, 1'($urandom_range(1, 0)), 1, 1'b0);

      // Abort an operation in its 4th BUSY cycle.
      a_i = 32'h55; b_i = 32'h11; borrow_i = 1'b0; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      chk("midrst_valid", {31'd0, valid_o}, 32'd0);
      chk("midrst_ready", {31'd0, ready_o}, 32'd0);
      tick();
      chk("midrst_valid_held", {31'd0, valid_o}, 32'd0);
      chk("midrst_ready_held", {31'd0, ready_o}, 32'd0);
      rst = 1'b0;
      tick();
      chk("midrst_ready_release", {31'd0, ready_o}, 32'd1);
      chk("midrst_valid_release", {31'd0, valid_o}, 32'd0);
      repeat (10) tick();
      chk("midrst_no_result", {31'd0, valid_o}, 32'd0);
      $display("op midrst: aborted operation produced valid_o=%0d", valid_o);
      do_op("post_rst", 32'd10, 32'd7, 1'b0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
